// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment driver with frame snapshot, dead-time
// between digit slots, leading-zero blanking and per-digit decimal points.
module seg7_scan_driver #(
   parameter int unsigned REFRESH_DIV = 100000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] dp_mask,
   output logic [3:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_tick
);

   localparam logic [19:0] LAST = 20'(REFRESH_DIV - 1);

   logic [19:0]     presc_q, presc_d;
   logic [1:0]      idx_q, idx_d;
   logic [3:0][3:0] digit_q, digit_d;
   logic [3:0]      dpm_q, dpm_d;
   logic [3:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            dp_q, dp_d;
   logic            tick_q, tick_d;
   logic [3:0]      blank;
   logic            load;

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   // A digit is blanked only if it and every digit to its left is zero.
   always_comb begin
      blank    = 4'b0000;
      blank[3] = BLANK_LZ && (digit_q[3] == 4'd0);
      blank[2] = blank[3] && (digit_q[2] == 4'd0);
      blank[1] = blank[2] && (digit_q[1] == 4'd0);
   end

   always_comb begin
      load    = en && (presc_q == 20'd0) && (idx_q == 2'd0);
      presc_d = presc_q;
      idx_d   = idx_q;
      digit_d = digit_q;
      dpm_d   = dpm_q;
      tick_d  = load;
      if (en) begin
         if (presc_q == LAST) begin
            presc_d = 20'd0;
            idx_d   = idx_q + 2'd1;
         end else begin
            presc_d = presc_q + 20'd1;
         end
      end
      if (load) begin
         digit_d = {d3, d2, d1, d0};
         dpm_d   = dp_mask;
      end
   end

   // Prescaler value 0 is the dark cycle that separates consecutive slots.
   always_comb begin
      an_d  = 4'b1111;
      seg_d = 7'h7F;
      if (en && !blank[idx_q]) begin
         seg_d = decode(digit_q[idx_q]);
         if (presc_q != 20'd0) begin
            an_d = ~(4'b0001 << idx_q);
         end
      end
      dp_d = ~(~an_d[idx_q] & dpm_q[idx_q]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q <= 20'd0;
         idx_q   <= 2'd0;
         digit_q <= '0;
         dpm_q   <= 4'b0000;
         an_q    <= 4'b1111;
         seg_q   <= 7'h7F;
         dp_q    <= 1'b1;
         tick_q  <= 1'b0;
      end else begin
         presc_q <= presc_d;
         idx_q   <= idx_d;
         digit_q <= digit_d;
         dpm_q   <= dpm_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         tick_q  <= tick_d;
      end
   end

   assign an         = an_q;
   assign seg        = seg_q;
   assign dp         = dp_q;
   assign frame_tick = tick_q;

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 100000: clk cycles per digit slot; legal range 2..2^20.
REQ-002 Parameter BLANK_LZ, default 1: 1 enables leading-zero blanking, 0 disables it.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 en  in  1  scan enable; 0 turns the display off and freezes the scan.
REQ-006 d0, d1, d2, d3  in  4 each  BCD digits; d0 is the rightmost (least significant) digit, d3 the leftmost.
REQ-007 dp_mask  in  4  decimal-point request; bit k applies to digit k.
REQ-008 an  out  4  digit anodes, active-low; an[k] selects digit k.
REQ-009 seg  out  7  cathodes, active-low, bit order {g,f,e,d,c,b,a}.
REQ-010 dp  out  1  decimal-point cathode, active-low.
REQ-011 frame_tick  out  1  one-cycle pulse at each snapshot load.

Function
REQ-012 The 20-bit prescaler shall count 0..REFRESH_DIV-1 while en=1, wrap to 0, and hold its value while en=0.
REQ-013 The 2-bit slot index shall advance 0->1->2->3->0 on each prescaler wrap, and shall hold its value while en=0.
REQ-014 On every cycle with en=1, prescaler=0 and index=0, the shadow registers shall load d0..d3 and dp_mask, and frame_tick shall be 1; frame_tick shall be 0 on all other cycles.
REQ-015 Decode and display shall use only the shadow registers, so input changes mid-frame do not appear until the next frame.
REQ-016 an, seg and dp shall be registered, each reflecting the index and prescaler values of the previous cycle (1-cycle latency).
REQ-017 Dead time: while prescaler=0, the next-state value of an shall be 4'b1111, giving one dark cycle per slot against ghosting.
REQ-018 Active slot: while prescaler is 1..REFRESH_DIV-1, an shall have only bit [index] low, unless that digit is blanked.
REQ-019 Decode (seg, hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
REQ-020 Shadow digit values 10..15 shall decode to a dash, seg=3F.
REQ-021 Leading-zero blanking (BLANK_LZ=1): digit k (k=1..3) is blanked when shadow digits k..3 are all 0.
REQ-022 Digit 0 shall never be blanked.
REQ-023 A blanked digit shall drive an=1111, seg=7F and dp=1 for its whole slot.
REQ-024 dp shall be 0 exactly when an[index] is low and the shadow dp_mask[index]=1; otherwise dp shall be 1.
REQ-025 While en=0, an, seg and dp shall register 1111, 7F and 1 respectively.
REQ-026 When en returns to 1, the prescaler and index shall resume from their held values.

Reset
REQ-027 While rst=1, independent of clk: prescaler=0, index=0, shadow digits=0, shadow dp_mask=0, an=1111, seg=7F, dp=1, frame_tick=0.
REQ-028 Asserting rst mid-slot shall force the REQ-027 values immediately.
REQ-029 After rst is released with en=1, the first clock edge shall load the snapshot and pulse frame_tick.

Verification (REFRESH_DIV=4, BLANK_LZ=1 unless stated)
REQ-030 d3..d0=4,3,2,1 -> per 4-cycle slot: one dark cycle, then 3 cycles of an=1110/seg=79, an=1101/24, an=1011/30, an=0111/19 in turn; frame_tick every 16 cycles.
REQ-031 Digits 0,0,0,0 -> only an=1110 ever lights, with seg=40.
REQ-032 Digits 0,0,5,0 -> digits 1 and 0 lit.
REQ-033 BLANK_LZ=0 with digits 0,0,5,0 -> all four digits lit.
REQ-034 d2=12 -> seg=3F in slot 2.
REQ-035 dp_mask=0100 -> dp=0 only during the active cycles of slot 2.
REQ-036 Change d0 during slot 2 -> the old value is shown in slot 0 until after the next frame_tick, and the new value from the following slot 0.
REQ-037 en=0 for 10 cycles mid-slot 1 -> an=1111, prescaler and index held; on en=1, slot 1 completes its remaining cycles.
REQ-038 rst pulsed mid-slot 3 -> outputs reach their reset values before the next clk edge; after release, frame_tick=1 on the first edge.
